// File: rtl/ps2_pkg.sv
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared PS/2 host-transmit types, frame constants and parity.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      SHIFT     = 3'd3,
      WAIT_IDLE = 3'd4
   } ps2_state_t;

   // Falling edges that carry data/parity/stop, and the edge on which ACK is read
   localparam logic [3:0] FRAME_EDGES = 4'd10;
   localparam logic [3:0] ACK_EDGE    = 4'd11;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_edge_sync.sv
// ============================================================================
//  Module      : ps2_edge_sync
//  Description : PS/2 clock/data synchronizer with clock falling-edge detect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_edge_sync (
   input  logic clk,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);

   logic [2:0] r_clk_sync;
   logic [1:0] r_data_sync;

   // Deliberately reset-free: the chains flush themselves within three clocks
   always_ff @(posedge clk) begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
   end

   assign clk_sync  = r_clk_sync[1];
   assign data_sync = r_data_sync[1];
   assign clk_fall  = r_clk_sync[2] & ~r_clk_sync[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter (open-drain drive).
//                Define PS2_TX_RETRY_EN for one automatic retry on failure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic             INH_ONE  = (INHIBIT_CYCLES == 1);

   ps2_state_t       r_state, w_state_nxt;
   logic [9:0]       r_frame, w_frame_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [3:0]       r_edge, w_edge_nxt, w_edge_n;
   logic             r_clk_oe, w_clk_oe_nxt;
   logic             r_data_oe, w_data_oe_nxt;
   logic             r_tx_ready, r_busy;
   logic             r_done, w_done_nxt;
   logic             r_ack_err, w_ack_err_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic             w_clk_sync, w_data_sync, w_clk_fall;
   logic             w_expired, w_ack_now, w_fail, w_fail_ack, w_retry_go;

   ps2_edge_sync u_sync (
      .clk       (clk),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .clk_sync  (w_clk_sync),
      .data_sync (w_data_sync),
      .clk_fall  (w_clk_fall)
   );

`ifdef PS2_TX_RETRY_EN
   logic r_retry;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)                 r_retry <= 1'b0;
      else if (r_state == IDLE)  r_retry <= 1'b0;
      else if (w_fail)           r_retry <= 1'b1;
   end

   assign w_retry_go = ~r_retry;
`else
   assign w_retry_go = 1'b0;
`endif

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_edge_n  = r_edge + 4'd1;
   assign w_expired = (r_cnt == TO_LAST);
   assign w_ack_now = w_clk_fall && (w_edge_n == ACK_EDGE);

   always_comb begin
      w_state_nxt   = r_state;
      w_frame_nxt   = r_frame;
      w_cnt_nxt     = w_cnt_inc;
      w_edge_nxt    = r_edge;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = r_data_oe;
      w_done_nxt    = 1'b0;
      w_ack_err_nxt = 1'b0;
      w_timeout_nxt = 1'b0;
      w_fail        = 1'b0;
      w_fail_ack    = 1'b0;

      case (r_state)
         IDLE: begin
            w_cnt_nxt     = '0;
            w_edge_nxt    = '0;
            w_data_oe_nxt = 1'b0;
            if (tx_valid && r_tx_ready) begin
               w_frame_nxt   = {1'b1, odd_parity(tx_data), tx_data};
               w_state_nxt   = INHIBIT;
               w_clk_oe_nxt  = 1'b1;
               w_data_oe_nxt = INH_ONE;
            end
         end
         INHIBIT: begin
            w_clk_oe_nxt = 1'b1;
            if (r_cnt == INH_LAST) begin
               // Start bit is already on the line; the timeout window opens now
               w_state_nxt   = REQ;
               w_clk_oe_nxt  = 1'b0;
               w_data_oe_nxt = 1'b1;
               w_cnt_nxt     = '0;
            end else begin
               w_data_oe_nxt = (w_cnt_inc == INH_LAST);
            end
         end
         REQ: begin
            if (w_expired) w_fail = 1'b1;
            else           w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_clk_fall) begin
               w_edge_nxt = w_edge_n;
               if (w_ack_now) begin
                  if (w_data_sync) begin
                     w_fail     = 1'b1;
                     w_fail_ack = 1'b1;
                  end else begin
                     w_state_nxt = WAIT_IDLE;
                  end
               end else if (w_edge_n <= FRAME_EDGES) begin
                  w_data_oe_nxt = ~r_frame[r_edge];
               end
            end
            if (w_expired && !w_ack_now) w_fail = 1'b1;
         end
         WAIT_IDLE: begin
            if (w_clk_sync && w_data_sync) begin
               w_done_nxt    = 1'b1;
               w_state_nxt   = IDLE;
               w_data_oe_nxt = 1'b0;
            end else if (w_expired) begin
               w_fail = 1'b1;
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_data_oe_nxt = 1'b0;
         end
      endcase

      if (w_fail) begin
         if (w_retry_go) begin
            w_state_nxt   = INHIBIT;
            w_cnt_nxt     = '0;
            w_edge_nxt    = '0;
            w_clk_oe_nxt  = 1'b1;
            w_data_oe_nxt = INH_ONE;
         end else begin
            w_state_nxt   = IDLE;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_ack_err_nxt = w_fail_ack;
            w_timeout_nxt = ~w_fail_ack;
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state    <= IDLE;
         r_frame    <= '0;
         r_cnt      <= '0;
         r_edge     <= '0;
         r_clk_oe   <= 1'b0;
         r_data_oe  <= 1'b0;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ack_err  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_frame    <= w_frame_nxt;
         r_cnt      <= w_cnt_nxt;
         r_edge     <= w_edge_nxt;
         r_clk_oe   <= w_clk_oe_nxt;
         r_data_oe  <= w_data_oe_nxt;
         r_tx_ready <= (w_state_nxt == IDLE);
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_done_nxt;
         r_ack_err  <= w_ack_err_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign tx_ready    = r_tx_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign ack_err     = r_ack_err;
   assign timeout     = r_timeout;

endmodule

`default_nettype wire
